// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encodings and default operand width for the divider
package divider_pkg;

    localparam int DIV_SIZE = 80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational radix-2 restoring division step
module div_step
    import divider_pkg::*;
#(
    parameter int div_size = DIV_SIZE
) (
    input  logic [div_size:0]   pr,
    input  logic                dividend_bit,
    input  logic [div_size-1:0] b,
    output logic [div_size:0]   pr_next,
    output logic                q_bit
);

    logic [div_size:0] shifted;
    logic [div_size:0] diff;

    // pr < b always holds, so pr[div_size] is 0; if it were set the shifted value
    // would exceed b and the modular subtraction below would still be exact.
    assign shifted = {pr[div_size-1:0], dividend_bit};
    assign diff    = shifted - {1'b0, b};
    assign q_bit   = pr[div_size] | (shifted >= {1'b0, b});
    assign pr_next = q_bit ? diff : shifted;

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential restoring divider, 2*div_size-bit dividend by div_size-bit divisor
module divider
    import divider_pkg::*;
#(
    parameter int div_size = DIV_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2*div_size-1:0] a,
    input  logic [div_size-1:0]   b,
    output logic [2*div_size-1:0] q,
    output logic [div_size-1:0]   r,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(2*div_size) + 1;
    localparam logic [CNT_W-1:0] ITERS    = CNT_W'(2*div_size);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(1);

    div_state_t state;
    div_state_t state_next;

    logic [CNT_W-1:0]      cnt;
    logic [2*div_size-1:0] dvd;
    logic [div_size-1:0]   b_reg;
    logic [div_size:0]     pr;
    logic [div_size:0]     pr_next;
    logic                  q_bit;

    div_step #(.div_size(div_size)) u_step (
        .pr           (pr),
        .dividend_bit (dvd[2*div_size-1]),
        .b            (b_reg),
        .pr_next      (pr_next),
        .q_bit        (q_bit)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = CALC;
            CALC:    if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // The dividend register doubles as the quotient: quotient bits enter at the LSB
    // as dividend bits leave at the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dvd      <= '0;
            b_reg    <= '0;
            pr       <= '0;
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        dvd   <= a;
                        b_reg <= b;
                        pr    <= '0;
                        cnt   <= ITERS;
                    end
                end
                CALC: begin
                    pr  <= pr_next;
                    dvd <= {dvd[2*div_size-2:0], q_bit};
                    cnt <= cnt - LAST_CNT;
                end
                DONE: begin
                    done     <= 1'b1;
                    div_zero <= (b_reg == '0);
                    // With b=0 every step subtracts nothing, so pr already ends up
                    // holding the low div_size bits of the dividend.
                    q        <= (b_reg == '0) ? '1 : dvd;
                    r        <= pr[div_size-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - randomized self-checking bench for divider against an arithmetic model
module tb_divider;

    localparam int W = 80;

    logic           clk;
    logic           rst_n;
    logic           en;
    logic [2*W-1:0] a_i;
    logic [W-1:0]   b_i;
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic           div_zero;

    int n_cmp = 0;
    int n_mis = 0;

    logic [2*W-1:0] prev_q;
    logic [W-1:0]   prev_r;

    divider #(.div_size(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .a        (a_i),
        .b        (b_i),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd80();
        logic [95:0] raw;
        raw = {$urandom, $urandom, $urandom};
        return raw[W-1:0] >> $urandom_range(0, W-1);
    endfunction

    // Called #1 after a rising edge; presents en this cycle and waits for done.
    task automatic run_div(input logic [2*W-1:0] aa, input logic [W-1:0] bb, input bit inject, input string tag);
        logic [2*W-1:0] eq;
        logic [W-1:0]   er;
        logic [2*W-1:0] rem;
        logic           ez;
        int             lat;
        int             extra;
        bit             seen;
        if (bb == '0) begin
            eq = '1;
            er = aa[W-1:0];
            ez = 1'b1;
        end else begin
            eq  = aa / {{W{1'b0}}, bb};
            rem = aa % {{W{1'b0}}, bb};
            er  = rem[W-1:0];
            ez  = 1'b0;
        end
        a_i = aa;
        b_i = bb;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        a_i = {rnd80(), rnd80()};
        b_i = rnd80();
        check_eq({tag, "_busy_start"}, busy, 1);
        check_eq({tag, "_done_start"}, done, 0);
        check_eq({tag, "_q_held"}, q, prev_q);
        check_eq({tag, "_r_held"}, r, prev_r);
        lat  = 0;
        seen = 0;
        while (lat < 400 && !seen) begin
            en = inject && (lat == 10 || lat == 159 || lat == 160);
            if (en) begin
                a_i = {rnd80(), rnd80()};
                b_i = rnd80();
            end
            @(posedge clk);
            lat++;
            #1;
            if (done) seen = 1;
        end
        en = 1'b0;
        check_eq({tag, "_done_seen"}, seen, 1);
        check_eq({tag, "_latency"}, lat, 161);
        check_eq({tag, "_q"}, q, eq);
        check_eq({tag, "_r"}, r, er);
        check_eq({tag, "_div_zero"}, div_zero, ez);
        check_eq({tag, "_busy_done"}, busy, 0);
        prev_q = eq;
        prev_r = er;
        if (inject) begin
            extra = 0;
            repeat (200) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check_eq({tag, "_extra_done"}, extra, 0);
            check_eq({tag, "_q_after"}, q, eq);
            check_eq({tag, "_r_after"}, r, er);
        end
    endtask

    task automatic reset_mid_div();
        int dones;
        a_i = {rnd80(), rnd80()};
        b_i = rnd80() | 80'd1;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        rst_n = 1'b0;
        en    = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        check_eq("rst_mid_q", q, 0);
        check_eq("rst_mid_r", r, 0);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_done", done, 0);
        check_eq("rst_mid_dz", div_zero, 0);
        rst_n  = 1'b1;
        prev_q = '0;
        prev_r = '0;
        dones  = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check_eq("rst_mid_no_done", dones, 0);
    endtask

    initial begin
        logic [2*W-1:0] m;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] prod;
        rst_n  = 1'b0;
        en     = 1'b0;
        a_i    = '0;
        b_i    = '0;
        prev_q = '0;
        prev_r = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_q", q, 0);
        check_eq("reset_r", r, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_dz", div_zero, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_div(160'd1000, 80'd7, 0, "d1000_7");
        m = {{W{1'b0}}, {W{1'b1}}};
        run_div(m * m, {W{1'b1}}, 0, "dmaxsq");
        run_div(160'd5, 80'd9, 0, "d5_9");
        run_div({2*W{1'b1}}, 80'd1, 0, "dall_1");
        run_div(160'h1_0000_0000_0000_0000_1234, 80'd0, 0, "dzero");
        run_div(160'd123456789, 80'd1000, 1, "dinject");
        reset_mid_div();
        run_div(160'd1000, 80'd7, 0, "after_rst");

        for (int i = 0; i < 120; i++) begin
            x    = rnd80();
            y    = rnd80() | 80'd1;
            prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            run_div(prod, y, 0, "chain");
            check_eq("chain_q_is_a", q, {{W{1'b0}}, x});
            check_eq("chain_r_zero", r, 0);
        end
        for (int i = 0; i < 100; i++) begin
            x = rnd80();
            y = ($urandom_range(0, 15) == 0) ? '0 : rnd80();
            run_div({rnd80(), x}, y, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
